// File: rtl/color_lut_corrector_pkg.sv
// Shared constants and types for the per-channel LUT colour corrector.
// Packet addresses are 10 bits: [9:8] picks the channel table, [7:0] the entry.
package color_lut_corrector_pkg;

    localparam int CH_W      = 8;
    localparam int NUM_CH    = 3;
    localparam int LUT_DEPTH = 2 ** CH_W;
    localparam int PKT_LEN   = NUM_CH * LUT_DEPTH;
    localparam int ADDR_W    = 10;
    localparam int PIX_W     = NUM_CH * CH_W;

    localparam int R_HI = 23;
    localparam int G_HI = 15;
    localparam int B_HI = 7;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PKT_LEN - 1);
    localparam logic [ADDR_W-1:0] FULL_ADDR = ADDR_W'(PKT_LEN);

    typedef enum logic [1:0] {
        CH_R    = 2'd0,
        CH_G    = 2'd1,
        CH_B    = 2'd2,
        CH_NONE = 2'd3
    } ch_sel_e;

endpackage

// File: rtl/lut_ram_256x8.sv
// One channel table: single write port plus a registered, read-first read port.
module lut_ram_256x8
    import color_lut_corrector_pkg::*;
(
    input  logic            clk,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_addr,
    input  logic [CH_W-1:0] wr_data,
    input  logic            rd_en,
    input  logic [CH_W-1:0] rd_addr,
    output logic [CH_W-1:0] rd_data
);

    logic [CH_W-1:0] mem [LUT_DEPTH];

    // Non-blocking read of mem returns the pre-write entry on an address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/color_lut_corrector.sv
// RGB stream colour correction through three 256x8 tables loaded from a 768-byte packet.
// The table read register is the pipeline stage, so the output mux after it keeps latency at one clock.
module color_lut_corrector
    import color_lut_corrector_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    input  logic [PIX_W-1:0] s_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic [PIX_W-1:0] m_axis_tdata,
    input  logic             SOP,
    input  logic             EOP,
    input  logic             VLD,
    input  logic [CH_W-1:0]  packet_data
);

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              table_valid;
    logic              load_start;
    logic              wr_fire;
    logic              use_lut;
    logic              sel_q;
    logic [PIX_W-1:0]  pix_q;
    ch_sel_e           wr_ch;
    logic [CH_W-1:0]   rd_data [NUM_CH];

    assign load_start = VLD & SOP;
    assign wr_addr    = load_start ? '0 : addr;
    assign wr_fire    = VLD && (wr_addr < FULL_ADDR);
    assign wr_ch      = ch_sel_e'(wr_addr[ADDR_W-1:CH_W]);
    // A pixel arriving on the SOP beat must already bypass the table being replaced.
    assign use_lut    = table_valid && !load_start;

    // Only a write that lands exactly on the last entry, with EOP, validates the tables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr        <= '0;
            table_valid <= 1'b0;
        end else if (VLD) begin
            if (EOP) begin
                addr        <= '0;
                table_valid <= !SOP && (addr == LAST_ADDR);
            end else if (SOP) begin
                addr        <= ADDR_W'(1);
                table_valid <= 1'b0;
            end else if (addr != FULL_ADDR) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lut
        lut_ram_256x8 u_lut (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_ch == ch_sel_e'(c))),
            .wr_addr (wr_addr[CH_W-1:0]),
            .wr_data (packet_data),
            .rd_en   (s_axis_tvalid),
            .rd_addr (s_axis_tdata[R_HI - c*CH_W -: CH_W]),
            .rd_data (rd_data[c])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            sel_q         <= 1'b0;
            pix_q         <= '0;
        end else begin
            m_axis_tvalid <= s_axis_tvalid;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
            if (s_axis_tvalid) begin
                sel_q <= use_lut;
                pix_q <= s_axis_tdata;
            end
        end
    end

    assign m_axis_tdata = sel_q ? {rd_data[0], rd_data[1], rd_data[2]} : pix_q;

endmodule

// File: tb/tb_color_lut_corrector.sv
// Directed load/stream sequence with random pixels, checked against a table-array reference model.
module tb_color_lut_corrector;

    logic        clk;
    logic        rst;
    logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast;
    logic [23:0] s_axis_tdata;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [23:0] m_axis_tdata;
    logic        SOP, EOP, VLD;
    logic [7:0]  packet_data;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ref_lut [3][256];
    bit          ref_tv;
    int          ref_addr;
    logic [23:0] ref_data;
    logic        ref_valid, ref_user, ref_last;

    color_lut_corrector dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .SOP           (SOP),
        .EOP           (EOP),
        .VLD           (VLD),
        .packet_data   (packet_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".tvalid"}, {23'd0, m_axis_tvalid}, {23'd0, ref_valid});
        check_output({tag, ".tuser"},  {23'd0, m_axis_tuser},  {23'd0, ref_user});
        check_output({tag, ".tlast"},  {23'd0, m_axis_tlast},  {23'd0, ref_last});
        check_output({tag, ".tdata"},  m_axis_tdata, ref_data);
    endtask

    // Table contents: 0 inverting, 1 R identity / G 0x55 / B i>>1, 2 scrambled
    function automatic logic [7:0] table_byte(input int mode, input int idx);
        int ch, e;
        ch = idx / 256;
        e  = idx % 256;
        case (mode)
            0:       return 8'(255 - e);
            1:       return (ch == 0) ? 8'(e) : (ch == 1) ? 8'h55 : 8'(e >> 1);
            default: return 8'(e * 37 + ch * 91 + 13);
        endcase
    endfunction

    // One clock: drive inputs, predict the registered outputs, advance the model, then check
    task automatic apply_stimulus(input string tag, input logic tv, input logic tu, input logic tl,
                                  input logic [23:0] td, input logic vld, input logic sop,
                                  input logic eop, input logic [7:0] pd);
        int idx;
        s_axis_tvalid = tv;
        s_axis_tuser  = tu;
        s_axis_tlast  = tl;
        s_axis_tdata  = td;
        VLD           = vld;
        SOP           = sop;
        EOP           = eop;
        packet_data   = pd;
        ref_valid = tv;
        ref_user  = tu;
        ref_last  = tl;
        if (tv) begin
            if (ref_tv && !(vld && sop))
                ref_data = {ref_lut[0][td[23:16]], ref_lut[1][td[15:8]], ref_lut[2][td[7:0]]};
            else
                ref_data = td;
        end
        if (vld) begin
            idx = sop ? 0 : ref_addr;
            if (idx < 768) ref_lut[idx / 256][idx % 256] = pd;
            if (eop) begin
                ref_tv   = (idx == 767);
                ref_addr = 0;
            end else begin
                if (sop) ref_tv = 1'b0;
                ref_addr = (idx < 768) ? idx + 1 : 768;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        ref_tv    = 1'b0;
        ref_addr  = 0;
        ref_valid = 1'b0;
        ref_user  = 1'b0;
        ref_last  = 1'b0;
        ref_data  = 24'h0;
    endtask

    task automatic idle_inputs();
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 24'h0;
        VLD           = 1'b0;
        SOP           = 1'b0;
        EOP           = 1'b0;
        packet_data   = 8'h0;
    endtask

    // Asynchronous reset asserted between edges, held across one edge with traffic present
    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'hFFFFFF;
        VLD           = 1'b1;
        SOP           = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_held");
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_table(input string tag, input int mode, input int len, input bit with_eop,
                              input bit stream);
        for (int i = 0; i < len; i++) begin
            logic pv;
            pv = stream ? 1'($urandom_range(0, 1)) : 1'b0;
            apply_stimulus(tag, pv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           24'($urandom), 1'b1, i == 0, with_eop && (i == len - 1),
                           table_byte(mode, i));
        end
    endtask

    task automatic random_pixels(input string tag, input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(tag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 24'($urandom), 1'b0,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // No table loaded: bypass with sideband alignment
        for (int i = 0; i < 4; i++) begin
            apply_stimulus("bypass", 1'b1, i == 0, i == 3, 24'h123456, 1'b0, 1'b0, 1'b0, 8'h00);
            check_output("bypass_lit", m_axis_tdata, 24'h123456);
        end
        apply_stimulus("bypass_idle", 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 8'h00);

        load_table("inv_load", 0, 768, 1'b1, 1'b0);
        apply_stimulus("inv_px", 1'b1, 1'b0, 1'b0, 24'h00FF80, 1'b0, 1'b0, 1'b0, 8'h00);
        check_output("inv_lit", m_axis_tdata, 24'hFF007F);

        load_table("mix_load", 1, 768, 1'b1, 1'b0);
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                apply_stimulus("frame", 1'b1, (row == 0) && (col == 0), col == 3, 24'($urandom),
                               1'b0, 1'b0, 1'b0, 8'h00);
        apply_stimulus("mix_px", 1'b1, 1'b0, 1'b0, 24'h10C8FE, 1'b0, 1'b0, 1'b0, 8'h00);
        check_output("mix_lit", m_axis_tdata, 24'h10557F);

        load_table("short_load", 1, 501, 1'b1, 1'b0);
        apply_stimulus("short_px", 1'b1, 1'b0, 1'b0, 24'hA0B0C0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_output("short_lit", m_axis_tdata, 24'hA0B0C0);

        load_table("good_load", 0, 768, 1'b1, 1'b0);
        load_table("reload_stream", 2, 768, 1'b1, 1'b1);
        random_pixels("after_reload", 40);

        load_table("abort_load", 1, 300, 1'b0, 1'b1);
        do_reset();
        apply_stimulus("abort_px", 1'b1, 1'b0, 1'b0, 24'h010203, 1'b0, 1'b0, 1'b0, 8'h00);
        check_output("abort_lit", m_axis_tdata, 24'h010203);
        load_table("restore_load", 0, 768, 1'b1, 1'b1);
        apply_stimulus("restore_px", 1'b1, 1'b0, 1'b0, 24'h010203, 1'b0, 1'b0, 1'b0, 8'h00);
        check_output("restore_lit", m_axis_tdata, 24'hFEFDFC);

        load_table("long_load", 1, 800, 1'b1, 1'b1);
        random_pixels("after_long", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
